// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, RV32I opcode/funct constants,
// datapath width default and immediate builders used by decode and alu.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32 x XLEN register file: two combinational read ports, one edge-written
// write port, x0 hard-wired to zero, synchronous active-low clear.
module regfile
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_r [32];

  // Register array update: clear on reset, otherwise accept writeback
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (wr_addr != 5'd0)) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Read port 1 with x0 forced to zero
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (rs1_addr != 5'd0) begin
      rs1_data = regs_r[rs1_addr];
    end else begin
      rs1_data = {XLEN{1'b0}};
    end
  end

  // Read port 2 with x0 forced to zero
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (rs2_addr != 5'd0) begin
      rs2_data = regs_r[rs2_addr];
    end else begin
      rs2_data = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register read, ALU-bundle decode and a single output
// register with valid/ready handshake. Optional same-cycle writeback bypass
// is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int          XLEN     = XLEN_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rd_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] rf_rs1_s;
  logic [XLEN-1:0] rf_rs2_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  alu_op_e         alu_op_s;
  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;
  logic            illegal_s;
  logic            rd_we_s;
  logic            capture_s;

  logic            out_valid_r;
  logic [XLEN-1:0] out_a_r;
  logic [XLEN-1:0] out_b_r;
  logic [3:0]      out_alu_op_r;
  logic [4:0]      out_rd_r;
  logic            out_rd_we_r;
  logic            out_illegal_r;
  logic [XLEN-1:0] out_pc_r;

  assign opcode_s = in_instr[6:0];
  assign rd_s     = in_instr[11:7];
  assign funct3_s = in_instr[14:12];
  assign rs1_s    = in_instr[19:15];
  assign rs2_s    = in_instr[24:20];
  assign shamt_s  = in_instr[24:20];
  assign funct7_s = in_instr[31:25];

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_s),
    .rs2_addr (rs2_s),
    .rs1_data (rf_rs1_s),
    .rs2_data (rf_rs2_s),
    .we       (wb_we),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

`ifdef DECODE_WB_BYPASS_EN
  // Operand select: forward a same-cycle writeback to matching sources
  always_comb begin
    rs1_val_s = rf_rs1_s;
    rs2_val_s = rf_rs2_s;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_s)) begin
      rs1_val_s = wb_data;
    end else begin
      rs1_val_s = rf_rs1_s;
    end
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_s)) begin
      rs2_val_s = wb_data;
    end else begin
      rs2_val_s = rf_rs2_s;
    end
  end
`else
  // Without bypass the operands see the pre-write register contents
  assign rs1_val_s = rf_rs1_s;
  assign rs2_val_s = rf_rs2_s;
`endif

  // Instruction decode into ALU operation and operands
  always_comb begin
    alu_op_s  = ALU_ADD;
    a_s       = rs1_val_s;
    b_s       = rs2_val_s;
    illegal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == F7_BASE) begin
          case (funct3_s)
            F3_ADD:  alu_op_s = ALU_ADD;
            F3_SLL:  alu_op_s = ALU_SLL;
            F3_SLT:  alu_op_s = ALU_SLT;
            F3_SLTU: alu_op_s = ALU_SLTU;
            F3_XOR:  alu_op_s = ALU_XOR;
            F3_SR:   alu_op_s = ALU_SRL;
            F3_OR:   alu_op_s = ALU_OR;
            F3_AND:  alu_op_s = ALU_AND;
            default: alu_op_s = ALU_ADD;
          endcase
        end else if ((funct7_s == F7_ALT) && (funct3_s == F3_ADD)) begin
          alu_op_s = ALU_SUB;
        end else if ((funct7_s == F7_ALT) && (funct3_s == F3_SR)) begin
          alu_op_s = ALU_SRA;
        end else begin
          illegal_s = 1'b1;
          alu_op_s  = ALU_ADD;
        end
      end
      OPC_OP_IMM: begin
        b_s = imm_i(in_instr);
        case (funct3_s)
          F3_ADD:  alu_op_s = ALU_ADD;
          F3_SLT:  alu_op_s = ALU_SLT;
          F3_SLTU: alu_op_s = ALU_SLTU;
          F3_XOR:  alu_op_s = ALU_XOR;
          F3_OR:   alu_op_s = ALU_OR;
          F3_AND:  alu_op_s = ALU_AND;
          F3_SLL: begin
            // shift immediates carry an unsigned shamt, not the sign-extended imm
            b_s = {{(XLEN-5){1'b0}}, shamt_s};
            if (funct7_s == F7_BASE) begin
              alu_op_s = ALU_SLL;
            end else begin
              illegal_s = 1'b1;
              alu_op_s  = ALU_ADD;
            end
          end
          F3_SR: begin
            b_s = {{(XLEN-5){1'b0}}, shamt_s};
            if (funct7_s == F7_BASE) begin
              alu_op_s = ALU_SRL;
            end else if (funct7_s == F7_ALT) begin
              alu_op_s = ALU_SRA;
            end else begin
              illegal_s = 1'b1;
              alu_op_s  = ALU_ADD;
            end
          end
          default: alu_op_s = ALU_ADD;
        endcase
      end
      OPC_LUI: begin
        alu_op_s = ALU_PASSB;
        a_s      = {XLEN{1'b0}};
        b_s      = imm_u(in_instr);
      end
      OPC_AUIPC: begin
        alu_op_s = ALU_ADD;
        a_s      = in_pc;
        b_s      = imm_u(in_instr);
      end
      default: begin
        illegal_s = 1'b1;
        alu_op_s  = ALU_ADD;
      end
    endcase
  end

  // Writeback request only for legal instructions targeting a real register
  always_comb begin
    rd_we_s = 1'b0;
    if (!illegal_s && (rd_s != 5'd0)) begin
      rd_we_s = 1'b1;
    end else begin
      rd_we_s = 1'b0;
    end
  end

  assign in_ready  = !out_valid_r || out_ready;
  assign capture_s = in_valid && in_ready;

  // Output bundle register; reset wins over flush, flush wins over capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_a_r       <= {XLEN{1'b0}};
      out_b_r       <= {XLEN{1'b0}};
      out_alu_op_r  <= 4'd0;
      out_rd_r      <= 5'd0;
      out_rd_we_r   <= 1'b0;
      out_illegal_r <= 1'b0;
      out_pc_r      <= RESET_PC;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (capture_s) begin
      out_valid_r   <= 1'b1;
      out_a_r       <= a_s;
      out_b_r       <= b_s;
      out_alu_op_r  <= alu_op_s;
      out_rd_r      <= rd_s;
      out_rd_we_r   <= rd_we_s;
      out_illegal_r <= illegal_s;
      out_pc_r      <= in_pc;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_a       = out_a_r;
  assign out_b       = out_b_r;
  assign out_alu_op  = out_alu_op_r;
  assign out_rd      = out_rd_r;
  assign out_rd_we   = out_rd_we_r;
  assign out_illegal = out_illegal_r;
  assign out_pc      = out_pc_r;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage with an instruction-level
// reference model; honours DECODE_WB_BYPASS_EN when defined.
module tb_decode_stage;

  localparam logic [31:0] RPC = 32'h0000_1000;

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        ill;
    logic [31:0] pc;
    bit          a_care;
    bit          b_care;
    bit          rd_care;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, wb_we, out_valid, out_ready;
  logic        out_rd_we, out_illegal;
  logic [31:0] in_instr, in_pc, wb_data, out_a, out_b, out_pc;
  logic [4:0]  wb_rd, out_rd;
  logic [3:0]  out_alu_op;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  bit          run_chk = 1'b0;
  bundle_t     exp_b;
  logic [31:0] mregs [32];
  logic [31:0] pc_ctr = 32'h0000_0100;

  decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Instruction semantics written from the ISA tables
  function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
      input logic [31:0] r1, input logic [31:0] r2);
    bundle_t d;
    int op_tab [8];
    int f3, f7, opc;
    logic [31:0] uimm, iimm;
    op_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    opc = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    uimm = ins & 32'hFFFF_F000;
    iimm = 32'($signed(ins) >>> 20);
    d = '{valid: 1'b1, a: r1, b: r2, op: 4'd0, rd: ins[11:7], rd_we: 1'b0, ill: 1'b0,
          pc: pc, a_care: 1'b1, b_care: 1'b1, rd_care: 1'b1};
    if (opc == 'h33) begin
      if (f7 == 0) d.op = 4'(op_tab[f3]);
      else if (f7 == 'h20 && f3 == 0) d.op = 4'd1;
      else if (f7 == 'h20 && f3 == 5) d.op = 4'd7;
      else d.ill = 1'b1;
    end else if (opc == 'h13) begin
      if (f3 == 1 || f3 == 5) begin
        d.b = 32'(ins[24:20]);
        if (f7 == 0) d.op = (f3 == 1) ? 4'd2 : 4'd6;
        else if (f3 == 5 && f7 == 'h20) d.op = 4'd7;
        else d.ill = 1'b1;
      end else begin
        d.b  = iimm;
        d.op = 4'(op_tab[f3]);
      end
    end else if (opc == 'h37) begin
      d.op = 4'd10; d.b = uimm; d.a_care = 1'b0;
    end else if (opc == 'h17) begin
      d.op = 4'd0; d.a = pc; d.b = uimm;
    end else begin
      d.ill = 1'b1;
    end
    if (d.ill) begin
      d.op = 4'd0; d.a_care = 1'b0; d.b_care = 1'b0; d.rd_care = 1'b0;
    end
    d.rd_we = !d.ill && (d.rd != 5'd0);
    return d;
  endfunction

  // Drive one cycle of inputs, advance the model, return at posedge+1
  task automatic step(input logic r, input logic iv, input logic [31:0] ins,
      input logic fl, input logic wwe, input logic [4:0] wrd,
      input logic [31:0] wd, input logic ordy);
    bundle_t nb;
    logic [31:0] r1, r2;
    rst_n = r; in_valid = iv; in_instr = ins; in_pc = pc_ctr; flush = fl;
    wb_we = wwe; wb_rd = wrd; wb_data = wd; out_ready = ordy;
    nb = exp_b;
    if (!r) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      nb = '{valid: 1'b0, a: 32'h0, b: 32'h0, op: 4'd0, rd: 5'd0, rd_we: 1'b0, ill: 1'b0,
             pc: RPC, a_care: 1'b1, b_care: 1'b1, rd_care: 1'b1};
    end else begin
      r1 = mregs[ins[19:15]];
      r2 = mregs[ins[24:20]];
`ifdef DECODE_WB_BYPASS_EN
      if (wwe && wrd != 5'd0 && wrd == ins[19:15]) r1 = wd;
      if (wwe && wrd != 5'd0 && wrd == ins[24:20]) r2 = wd;
`endif
      if (fl) nb.valid = 1'b0;
      else if (iv && (!exp_b.valid || ordy)) nb = model_decode(ins, pc_ctr, r1, r2);
      else if (ordy) nb.valid = 1'b0;
      if (wwe && wrd != 5'd0) mregs[wrd] = wd;
    end
    @(posedge clk);
    #1;
    exp_b = nb;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic issue(input logic [31:0] ins, input logic ordy);
    step(1'b1, 1'b1, ins, 1'b0, 1'b0, 5'd0, 32'h0, ordy);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] val);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, rd, val, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[31:25] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
    case (k)
      0, 1, 2: w[6:0] = 7'b0110011;
      3, 4, 5: w[6:0] = 7'b0010011;
      6:       w[6:0] = 7'b0110111;
      7:       w[6:0] = 7'b0010111;
      default: w[6:0] = 7'($urandom);
    endcase
    return w;
  endfunction

  // Cycle-by-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (run_chk) begin
      chk("out_valid", 32'(out_valid), 32'(exp_b.valid));
      chk("in_ready", 32'(in_ready), 32'(!exp_b.valid || out_ready));
      if (exp_b.valid) begin
        chk("alu_op", 32'(out_alu_op), 32'(exp_b.op));
        chk("illegal", 32'(out_illegal), 32'(exp_b.ill));
        chk("rd_we", 32'(out_rd_we), 32'(exp_b.rd_we));
        chk("pc", out_pc, exp_b.pc);
        if (exp_b.a_care) chk("a", out_a, exp_b.a);
        if (exp_b.b_care) chk("b", out_b, exp_b.b);
        if (exp_b.rd_care) chk("rd", 32'(out_rd), 32'(exp_b.rd));
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; out_ready = 1'b0;
    exp_b = '{valid: 1'b0, a: 32'h0, b: 32'h0, op: 4'd0, rd: 5'd0, rd_we: 1'b0, ill: 1'b0,
              pc: RPC, a_care: 1'b1, b_care: 1'b1, rd_care: 1'b1};
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

    // reset overrides capture, flush and writeback
    step(1'b0, 1'b1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1, 1'b1, 5'd1, 32'hDEAD, 1'b0);
    step(1'b0, 1'b1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b0, 1'b1, 5'd1, 32'hDEAD, 1'b0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_a", out_a, 32'h0);
    chk("rst_b", out_b, 32'h0);
    chk("rst_op", 32'(out_alu_op), 32'h0);
    chk("rst_rd", 32'(out_rd), 32'h0);
    chk("rst_rd_we", 32'(out_rd_we), 32'h0);
    chk("rst_illegal", 32'(out_illegal), 32'h0);
    chk("rst_pc", out_pc, 32'h0000_1000);
    run_chk = 1'b1;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("in_ready_after_reset", 32'(in_ready), 32'h1);

    issue(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd3), 1'b1);
    chk("x1_cleared_by_reset", out_a, 32'h0);

    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1);
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd3);
    chk("add_op", 32'(out_alu_op), 32'd0);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_rd_we", 32'(out_rd_we), 32'h1);

    issue(rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1);
    chk("sub_op", 32'(out_alu_op), 32'd1);
    chk("sub_b", out_b, 32'd3);
    issue({12'hFFF, 5'd1, 3'd0, 5'd4, 7'b0010011}, 1'b1);
    chk("addi_op", 32'(out_alu_op), 32'd0);
    chk("addi_b", out_b, 32'hFFFF_FFFF);

    for (int i = 0; i < 3; i++) begin
      issue(rtype(7'h00, 5'd2, 5'd1, 3'd6, 5'd6), 1'b0);
      chk("stall_b", out_b, 32'hFFFF_FFFF);
      chk("stall_rd", 32'(out_rd), 32'd4);
      chk("stall_in_ready", 32'(in_ready), 32'h0);
    end
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd6, 5'd6), 1'b1);
    chk("release_op", 32'(out_alu_op), 32'd8);
    chk("release_rd", 32'(out_rd), 32'd6);

    step(1'b1, 1'b1, {20'h12345, 5'd5, 7'b0110111}, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'h0);
    issue({20'h12345, 5'd5, 7'b0110111}, 1'b1);
    chk("lui_op", 32'(out_alu_op), 32'd10);
    chk("lui_b", out_b, 32'h1234_5000);
    issue(32'h0000_0180, 1'b1);
    chk("illegal_flag", 32'(out_illegal), 32'h1);
    chk("illegal_rd_we", 32'(out_rd_we), 32'h0);
    chk("illegal_op", 32'(out_alu_op), 32'd0);

    step(1'b1, 1'b1, rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd3), 1'b0, 1'b1, 5'd1, 32'd9, 1'b1);
`ifdef DECODE_WB_BYPASS_EN
    chk("same_cycle_wb_a", out_a, 32'd9);
`else
    chk("same_cycle_wb_a", out_a, 32'd5);
`endif
    wb(5'd0, 32'd7);
    issue(rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 1'b1);
    chk("x0_read_a", out_a, 32'h0);
    chk("x0_read_b", out_b, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), rand_instr(),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 0),
           5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 63) == 0) pc_ctr = $urandom & 32'hFFFF_FFFC;
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath width; only 32 is supported.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the out_pc value driven while in reset.
REQ-003 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-004 Ports SHALL be:
 clk  in  1  rising-edge clock
 rst_n  in  1  synchronous active-low reset
 in_valid  in  1  fetch offers an instruction
 in_ready  out  1  stage accepts the instruction this cycle
 in_instr  in  32  RV32I instruction word
 in_pc  in  32  address of in_instr
 flush  in  1  discard the held instruction
 wb_we  in  1  writeback register write enable
 wb_rd  in  5  writeback destination index
 wb_data  in  32  writeback value
 out_valid  out  1  decoded bundle valid for the ALU
 out_ready  in  1  execute consumes the bundle
 out_a  out  32  ALU operand a
 out_b  out  32  ALU operand b
 out_alu_op  out  4  ALU operation code
 out_rd  out  5  destination register
 out_rd_we  out  1  result to be written back
 out_illegal  out  1  unsupported encoding
 out_pc  out  32  pc of the bundle

Function
REQ-005 ALU codes SHALL be ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
REQ-006 OP (0110011) SHALL map funct7/funct3 to the matching code, a=rs1, b=rs2; funct7=0100000 selects SUB (funct3=000) or SRA (funct3=101).
REQ-007 OP-IMM (0010011) SHALL use a=rs1, b=sign-extended I-immediate; shifts use b=zero-extended shamt, with SRAI on imm[10]=1.
REQ-008 LUI SHALL give PASSB with b={imm[31:12],12'b0}; AUIPC SHALL give ADD with a=in_pc, b={imm[31:12],12'b0}.
REQ-009 Any other opcode, or a bad funct7 in OP or in an OP-IMM shift, SHALL set out_illegal=1, out_rd_we=0, out_alu_op=ADD.
REQ-010 out_rd_we SHALL be 1 only for legal instructions with rd!=0.
REQ-011 The output register SHALL be a single stage with 1-cycle latency: a bundle accepted at edge N is valid after edge N.
REQ-012 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-013 Capture SHALL occur on in_valid && in_ready; out_valid SHALL clear on out_ready with no capture.
REQ-014 The output bundle SHALL hold stable while out_valid && !out_ready.
REQ-015 flush SHALL take priority over capture: out_valid=0 next cycle and the incoming instruction is dropped.
REQ-016 The register file SHALL have 32x32 entries, with two combinational read ports and one write port written at the clock edge.
REQ-017 x0 SHALL always read 0; writes to x0 SHALL be ignored.

Reset
REQ-018 While rst_n=0 at an edge: out_valid=0, out_a=out_b=0, out_alu_op=0, out_rd=0, out_rd_we=0, out_illegal=0, out_pc=RESET_PC, all registers=0.
REQ-019 Reset SHALL override flush, capture and writeback in the same cycle; in_ready SHALL read 1 after reset.

Configuration
REQ-020 Macro DECODE_WB_BYPASS_EN defined: when wb_we=1, wb_rd!=0 and wb_rd equals rs1/rs2 in the same cycle, the operand SHALL be wb_data.
REQ-021 Macro undefined: the operand SHALL be the pre-write register value, and the write SHALL be visible from the next cycle.

Structure
REQ-022 ALU op codes, opcode/funct constants and the XLEN default SHALL live in shared package cpu_pkg, also used by alu.
REQ-023 The register file SHALL be sub-module regfile; decode logic and the output register stay in decode_stage.

Verification
REQ-024 Reset, then wb x1=5, x2=3, then issue "add x3,x1,x2" -> one cycle later out_valid=1, a=5, b=3, op=ADD, rd=3, rd_we=1.
REQ-025 Issue "sub x3,x1,x2", then "addi x4,x1,-1" -> op=SUB, b=3; then op=ADD, b=32'hFFFF_FFFF.
REQ-026 Hold out_ready=0 for 3 cycles with a bundle valid -> bundle stable and in_ready=0; release -> next bundle captured that edge.
REQ-027 flush together with in_valid -> out_valid=0 next cycle; "lui x5,0x12345" -> PASSB, b=32'h1234_5000; opcode 0000000 -> out_illegal=1, rd_we=0.
REQ-028 Same-cycle wb x1=9 with "add x3,x1,x0" -> a=9 with DECODE_WB_BYPASS_EN, a=5 without; a write to x0 then a read of it -> 0.
